// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stage indices, stall
// encoding and FSM state encoding.
package pipe_ctrl_pkg;

  localparam int PC_STAGE  = 0;
  localparam int IF_STAGE  = 1;
  localparam int ID_STAGE  = 2;
  localparam int EX_STAGE  = 3;
  localparam int MEM_STAGE = 4;
  localparam int WB_STAGE  = 5;
  localparam int STAGE_NUM = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam logic TRUE    = 1'b1;
  localparam logic FALSE   = 1'b0;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle: per-stage stall requests and branch resolution
// from the core, stall/flush/redirect and debug counters back to it.
interface pipe_ctrl_if #(
  parameter int STAGE_NUM  = 6,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic                  if_stall_req;
  logic                  id_stall_req;
  logic                  ex_stall_req;
  logic                  mem_stall_req;
  logic                  branch_req;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic [STAGE_NUM-1:0]  stall;
  logic                  flush;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic [CNT_WIDTH-1:0]  stall_cnt;
  logic [CNT_WIDTH-1:0]  flush_cnt;

  modport master (
    output if_stall_req, id_stall_req, ex_stall_req, mem_stall_req,
    output branch_req, branch_target,
    input  stall, flush, redirect_valid, redirect_pc, stall_cnt, flush_cnt
  );

  modport slave (
    input  if_stall_req, id_stall_req, ex_stall_req, mem_stall_req,
    input  branch_req, branch_target,
    output stall, flush, redirect_valid, redirect_pc, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Free-running event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;

  // Count qualifying cycles, holding once saturated.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests into the shared stall
// vector and issues flush/PC redirect for branches resolved in EX, holding
// the redirect back while an instruction fetch is still in flight.
//
//   state | meaning
//   RUN   | normal flow; taken branch redirects at once if fetch is idle
//   DRAIN | branch accepted, waiting for the outstanding fetch to return
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGE_NUM  = 6,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic          clk,
  input  logic          rstn,
  pipe_ctrl_if.slave    bus
);

  pc_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] target_q, target_d;
  logic [STAGE_NUM-1:0]  stall_d;
  logic [2:0]            hi_stage;
  logic                  accept;
  logic                  flush_d;
  logic                  redirect_valid_d;
  logic [ADDR_WIDTH-1:0] redirect_pc_d;

  // Highest requesting stage stops itself and everything upstream of it.
  always_comb begin
    hi_stage = 3'd0;
    if (bus.mem_stall_req)     hi_stage = 3'(MEM_STAGE);
    else if (bus.ex_stall_req) hi_stage = 3'(EX_STAGE);
    else if (bus.id_stall_req) hi_stage = 3'(ID_STAGE);
    else if (bus.if_stall_req) hi_stage = 3'(IF_STAGE);
    stall_d = '0;
    for (int i = 0; i < STAGE_NUM; i++) begin
      stall_d[i] = ((hi_stage != 3'd0) && (i <= int'(hi_stage))) ? STOP : NO_STOP;
    end
  end

  // A stalled EX re-presents its branch later, so only take it when EX moves.
  assign accept = (state_q == RUN) && (stall_d[EX_STAGE] == NO_STOP) && bus.branch_req;

  // State and held redirect target.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= RUN;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  // Next state and combinational flush/redirect outputs.
  always_comb begin
    state_d          = state_q;
    target_d         = target_q;
    flush_d          = FALSE;
    redirect_valid_d = FALSE;
    redirect_pc_d    = (state_q == DRAIN) ? target_q : '0;
    unique case (state_q)
      RUN: begin
        if (accept) begin
          flush_d = TRUE;
          if (!bus.if_stall_req) begin
            redirect_valid_d = TRUE;
            redirect_pc_d    = bus.branch_target;
          end else begin
            target_d = bus.branch_target;
            state_d  = DRAIN;
          end
        end
      end
      DRAIN: begin
        // The returning fetch is wrong-path, so it is flushed with the redirect.
        if (stall_d[IF_STAGE] == NO_STOP) begin
          flush_d          = TRUE;
          redirect_valid_d = TRUE;
          redirect_pc_d    = target_q;
          state_d          = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign bus.stall          = stall_d;
  assign bus.flush          = flush_d;
  assign bus.redirect_valid = redirect_valid_d;
  assign bus.redirect_pc    = redirect_pc_d;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (stall_d[PC_STAGE] == STOP),
    .cnt  (bus.stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (accept),
    .cnt  (bus.flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl plus a narrow sat_counter for wrap-around.
module tb_pipe_ctrl;

  logic clk;
  logic rstn;
  logic sat_inc;
  logic [1:0] sat_cnt;
  int total;
  int bad;
  int exp_sc;
  int exp_fc;

  pipe_ctrl_if #(.STAGE_NUM(6), .ADDR_WIDTH(32), .CNT_WIDTH(32)) bus ();

  pipe_ctrl #(.STAGE_NUM(6), .ADDR_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  sat_counter #(.WIDTH(2)) u_sat (
    .clk  (clk),
    .rstn (rstn),
    .inc  (sat_inc),
    .cnt  (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.if_stall_req  = 1'b0;
    bus.id_stall_req  = 1'b0;
    bus.ex_stall_req  = 1'b0;
    bus.mem_stall_req = 1'b0;
    bus.branch_req    = 1'b0;
    bus.branch_target = 32'h0;
  endtask

  task automatic test_reset();
    clear_inputs();
    sat_inc = 1'b0;
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    #1;
    total++; if (bus.stall !== 6'b000000) begin bad++; $display("FAIL reset_stall got=%b want=%b", bus.stall, 6'b000000); end
    total++; if (bus.flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b want=0", bus.flush); end
    total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL reset_rv got=%b want=0", bus.redirect_valid); end
    total++; if (bus.redirect_pc !== 32'h0) begin bad++; $display("FAIL reset_rpc got=%h want=0", bus.redirect_pc); end
    tick();
    total++; if (bus.stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_scnt got=%0d want=0", bus.stall_cnt); end
    total++; if (bus.flush_cnt !== 32'd0) begin bad++; $display("FAIL reset_fcnt got=%0d want=0", bus.flush_cnt); end
    exp_sc = 0;
    exp_fc = 0;
  endtask

  task automatic test_stall_decode();
    logic [5:0] want [4];
    logic [3:0] req  [4];
    // req bits: {mem, ex, id, if}
    req[0] = 4'b1010; want[0] = 6'b011111;
    req[1] = 4'b0010; want[1] = 6'b000111;
    req[2] = 4'b0001; want[2] = 6'b000011;
    req[3] = 4'b0100; want[3] = 6'b001111;
    for (int i = 0; i < 4; i++) begin
      bus.mem_stall_req = req[i][3];
      bus.ex_stall_req  = req[i][2];
      bus.id_stall_req  = req[i][1];
      bus.if_stall_req  = req[i][0];
      #1;
      total++; if (bus.stall !== want[i]) begin bad++; $display("FAIL stall_vec%0d got=%b want=%b", i, bus.stall, want[i]); end
      tick();
      exp_sc++;
      total++; if (bus.stall_cnt !== 32'(exp_sc)) begin bad++; $display("FAIL stall_cnt%0d got=%0d want=%0d", i, bus.stall_cnt, exp_sc); end
    end
    clear_inputs();
    #1;
    total++; if (bus.stall !== 6'b000000) begin bad++; $display("FAIL stall_idle got=%b want=000000", bus.stall); end
    tick();
    total++; if (bus.stall_cnt !== 32'(exp_sc)) begin bad++; $display("FAIL stall_cnt_hold got=%0d want=%0d", bus.stall_cnt, exp_sc); end
  endtask

  task automatic test_branch_fast();
    bus.branch_req    = 1'b1;
    bus.branch_target = 32'h0000_0100;
    #1;
    total++; if (bus.flush !== 1'b1) begin bad++; $display("FAIL fast_flush got=%b want=1", bus.flush); end
    total++; if (bus.redirect_valid !== 1'b1) begin bad++; $display("FAIL fast_rv got=%b want=1", bus.redirect_valid); end
    total++; if (bus.redirect_pc !== 32'h100) begin bad++; $display("FAIL fast_rpc got=%h want=100", bus.redirect_pc); end
    tick();
    exp_fc++;
    total++; if (bus.flush_cnt !== 32'(exp_fc)) begin bad++; $display("FAIL fast_fcnt got=%0d want=%0d", bus.flush_cnt, exp_fc); end
    clear_inputs();
    #1;
    total++; if ({bus.flush, bus.redirect_valid} !== 2'b00) begin bad++; $display("FAIL fast_idle got=%b want=00", {bus.flush, bus.redirect_valid}); end
    total++; if (bus.redirect_pc !== 32'h0) begin bad++; $display("FAIL fast_idle_rpc got=%h want=0", bus.redirect_pc); end
    tick();
  endtask

  task automatic test_drain();
    bus.branch_req    = 1'b1;
    bus.branch_target = 32'h0000_0200;
    bus.if_stall_req  = 1'b1;
    #1;
    total++; if (bus.flush !== 1'b1) begin bad++; $display("FAIL drain_first_flush got=%b want=1", bus.flush); end
    total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL drain_first_rv got=%b want=0", bus.redirect_valid); end
    tick();
    exp_sc++;
    exp_fc++;
    bus.branch_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if ({bus.flush, bus.redirect_valid} !== 2'b00) begin bad++; $display("FAIL drain_wait%0d got=%b want=00", i, {bus.flush, bus.redirect_valid}); end
      total++; if (bus.redirect_pc !== 32'h200) begin bad++; $display("FAIL drain_wait_rpc%0d got=%h want=200", i, bus.redirect_pc); end
      tick();
      exp_sc++;
    end
    bus.if_stall_req = 1'b0;
    #1;
    total++; if ({bus.flush, bus.redirect_valid} !== 2'b11) begin bad++; $display("FAIL drain_release got=%b want=11", {bus.flush, bus.redirect_valid}); end
    total++; if (bus.redirect_pc !== 32'h200) begin bad++; $display("FAIL drain_release_rpc got=%h want=200", bus.redirect_pc); end
    tick();
    total++; if ({bus.flush, bus.redirect_valid} !== 2'b00) begin bad++; $display("FAIL drain_after got=%b want=00", {bus.flush, bus.redirect_valid}); end
    total++; if (bus.redirect_pc !== 32'h0) begin bad++; $display("FAIL drain_after_rpc got=%h want=0", bus.redirect_pc); end
    total++; if (bus.flush_cnt !== 32'(exp_fc)) begin bad++; $display("FAIL drain_fcnt got=%0d want=%0d", bus.flush_cnt, exp_fc); end
    total++; if (bus.stall_cnt !== 32'(exp_sc)) begin bad++; $display("FAIL drain_scnt got=%0d want=%0d", bus.stall_cnt, exp_sc); end
    clear_inputs();
  endtask

  task automatic test_branch_blocked();
    bus.branch_req    = 1'b1;
    bus.branch_target = 32'h0000_0300;
    bus.mem_stall_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if ({bus.flush, bus.redirect_valid} !== 2'b00) begin bad++; $display("FAIL blocked%0d got=%b want=00", i, {bus.flush, bus.redirect_valid}); end
      tick();
      exp_sc++;
    end
    total++; if (bus.flush_cnt !== 32'(exp_fc)) begin bad++; $display("FAIL blocked_fcnt got=%0d want=%0d", bus.flush_cnt, exp_fc); end
    bus.mem_stall_req = 1'b0;
    #1;
    total++; if ({bus.flush, bus.redirect_valid} !== 2'b11) begin bad++; $display("FAIL blocked_accept got=%b want=11", {bus.flush, bus.redirect_valid}); end
    total++; if (bus.redirect_pc !== 32'h300) begin bad++; $display("FAIL blocked_rpc got=%h want=300", bus.redirect_pc); end
    tick();
    exp_fc++;
    total++; if (bus.flush_cnt !== 32'(exp_fc)) begin bad++; $display("FAIL blocked_fcnt2 got=%0d want=%0d", bus.flush_cnt, exp_fc); end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_in_drain();
    bus.branch_req    = 1'b1;
    bus.branch_target = 32'h0000_0400;
    bus.if_stall_req  = 1'b1;
    tick();
    bus.branch_req = 1'b0;
    #1;
    total++; if (bus.redirect_pc !== 32'h400) begin bad++; $display("FAIL rd_in_drain_rpc got=%h want=400", bus.redirect_pc); end
    rstn = 1'b0;
    bus.if_stall_req = 1'b0;
    #1;
    total++; if ({bus.flush, bus.redirect_valid} !== 2'b00) begin bad++; $display("FAIL rd_async got=%b want=00", {bus.flush, bus.redirect_valid}); end
    total++; if (bus.redirect_pc !== 32'h0) begin bad++; $display("FAIL rd_async_rpc got=%h want=0", bus.redirect_pc); end
    total++; if (bus.flush_cnt !== 32'd0 || bus.stall_cnt !== 32'd0) begin bad++; $display("FAIL rd_cnts got=%0d/%0d want=0/0", bus.stall_cnt, bus.flush_cnt); end
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if ({bus.flush, bus.redirect_valid} !== 2'b00) begin bad++; $display("FAIL rd_release%0d got=%b want=00", i, {bus.flush, bus.redirect_valid}); end
      total++; if (bus.redirect_pc !== 32'h0) begin bad++; $display("FAIL rd_release_rpc%0d got=%h want=0", i, bus.redirect_pc); end
      total++; if (bus.stall !== 6'b000000) begin bad++; $display("FAIL rd_release_stall%0d got=%b want=000000", i, bus.stall); end
      tick();
    end
    total++; if (bus.flush_cnt !== 32'd0) begin bad++; $display("FAIL rd_fcnt got=%0d want=0", bus.flush_cnt); end
  endtask

  task automatic test_saturation();
    sat_inc = 1'b1;
    tick();
    tick();
    total++; if (sat_cnt !== 2'd2) begin bad++; $display("FAIL sat_mid got=%0d want=2", sat_cnt); end
    tick();
    tick();
    tick();
    total++; if (sat_cnt !== 2'd3) begin bad++; $display("FAIL sat_hold got=%0d want=3", sat_cnt); end
    sat_inc = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_stall_decode();
    test_branch_fast();
    test_drain();
    test_branch_blocked();
    test_reset_in_drain();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Merges per-stage stall requests into the shared `stall` vector consumed by every pipeline register (pc_reg, if_id, id_ex, ex_mem, mem_wb).
- Generates `flush` and the PC redirect for taken branches/jumps resolved in EX, deferring the redirect while an instruction fetch is still outstanding.
- Keeps saturating stall/flush counters for performance debug.

Parameters:
- STAGE_NUM, 6, width of the stall vector. Indices: PC=0, IF=1, ID=2, EX=3, MEM=4, WB=5.
- ADDR_WIDTH, 32, PC/target width.
- CNT_WIDTH, 32, performance counter width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- if_stall_req  in  1  fetch not complete (IM busy).
- id_stall_req  in  1  load-use hazard in ID.
- ex_stall_req  in  1  multi-cycle EX operation busy.
- mem_stall_req  in  1  data memory access not complete.
- branch_req  in  1  EX resolved a taken branch/jump this cycle.
- branch_target  in  ADDR_WIDTH  redirect address qualifying branch_req.
- stall  out  STAGE_NUM  per-stage hold, `Stop`/`NoStop`.
- flush  out  1  kill wrong-path contents of IF/ID and ID/EX.
- redirect_valid  out  1  PC register loads redirect_pc at next edge.
- redirect_pc  out  ADDR_WIDTH  redirect address.
- stall_cnt  out  CNT_WIDTH  cycles with stall[PC]==Stop.
- flush_cnt  out  CNT_WIDTH  accepted branch redirects.

Behaviour:
- Reset (rstn=0, async): state=RUN, held target=0, both counters=0. Outputs are driven from reset state: stall all `NoStop`, flush=0, redirect_valid=0, redirect_pc=0.
- Stall decode is combinational, zero latency. The highest requesting stage k sets stall[0..k]=`Stop` and all others `NoStop`.
  - k is the highest of: MEM (4) > EX (3) > ID (2) > IF (1).
  - No requests: all `NoStop`. stall[WB] is always `NoStop`.
- Register rule (for the consumers): a register after stage i inserts a bubble when stall[i]=`Stop` and stall[i+1]=`NoStop`.
- Branch acceptance: branch_req is accepted only in a cycle with stall[EX]=`NoStop` and state=RUN. Otherwise it is ignored, because EX still holds the branch and re-presents it.
- State machine, two states:
  - RUN, accept and if_stall_req=0: flush=1, redirect_valid=1, redirect_pc=branch_target, all combinational in the same cycle. Stay in RUN.
  - RUN, accept and if_stall_req=1: flush=1, redirect_valid=0, latch branch_target, go to DRAIN.
  - DRAIN, stall[IF]=`Stop` (fetch outstanding or a downstream stall): outputs idle except stall. Stay in DRAIN.
  - DRAIN, stall[IF]=`NoStop`: flush=1 (discards the returning wrong-path fetch), redirect_valid=1, redirect_pc=latched target. Go to RUN.
  - In DRAIN, branch_req is ignored. It cannot legally occur because EX holds only bubbles.
- flush overrides stall at the consumers. In RUN, flush is never asserted while stall[EX]=`Stop`.
- Outside an asserted redirect_valid, redirect_pc is 0 in RUN and the latched target in DRAIN.
- Counters:
  - stall_cnt increments in each cycle with stall[PC]=`Stop`.
  - flush_cnt increments once per accepted branch, not once per flush pulse.
  - Both saturate at all-ones.
- Reset asserted mid-DRAIN returns to RUN immediately and drops the pending redirect.

Decomposition:
- Add to def.v: stage index macros (PC_STAGE..WB_STAGE), `STAGE_NUM`, `Stop`/`NoStop`, `True`/`False`, and the pipe_ctrl state encoding (RUN=1'b0, DRAIN=1'b1).
- One sub-module, sat_counter (parameter WIDTH; ports clk, rstn, inc, cnt), instantiated twice.

Test Plan:
- Reset release with no requests: stall=6'b000000, flush=0, redirect_valid=0, counters=0.
- Requests id+mem high together: stall=6'b011111. Then mem low, id high: stall=6'b000111. stall_cnt rises by 1 per cycle.
- RUN, branch_req=1, target=32'h0000_0100, no stalls: in the same cycle flush=1, redirect_valid=1, redirect_pc=32'h100. flush_cnt=1 after the edge.
- branch_req=1, target=32'h0000_0200, if_stall_req=1 for 3 cycles: flush=1 in the first cycle only, redirect_valid=0 through the wait. In the cycle if_stall_req falls, flush=1, redirect_valid=1, redirect_pc=32'h200. flush_cnt increments by 1 total.
- branch_req=1 while mem_stall_req=1: no flush, no redirect, flush_cnt unchanged. Once mem_stall_req drops with branch_req still high, the branch is accepted once.
- Assert rstn=0 mid-DRAIN, then release with if_stall_req=0: no redirect issued, state RUN, all outputs at reset values.
